// File: rtl/obc_pkg.sv
// obc_pkg -- shared definitions for the OBC DFT datapath.
// Used by the bit-serial scheduler, the twiddle-sum ROMs and the top-level DFT.
//   NUM_TAPS      : samples per partial sum (ROM address width)
//   DEF_DW/DEF_RW : default sample / ROM word widths
//   ROM_FRAC_BITS : binary point position of ROM words and results
//   obc_state_e   : scheduler states
//   ACC_*         : shift-accumulator op codes
package obc_pkg;
  localparam int NUM_TAPS      = 8;
  localparam int DEF_DW        = 8;
  localparam int DEF_RW        = 32;
  localparam int ROM_FRAC_BITS = 21;

  typedef enum logic [1:0] {IDLE, RUN, OFFS, DONE} obc_state_e;

  localparam logic [1:0] ACC_CLR  = 2'd0;  // acc = 0
  localparam logic [1:0] ACC_DADD = 2'd1;  // acc = 2*acc + operand
  localparam logic [1:0] ACC_DSUB = 2'd2;  // acc = 2*acc - operand
  localparam logic [1:0] ACC_ADD  = 2'd3;  // acc = acc + operand
endpackage

// File: rtl/obc_shift_acc.sv
// obc_shift_acc -- AW-bit wrapping shift-accumulator.
//   clk, rst_n : clock, async active-low reset (acc -> 0)
//   en         : perform op this cycle, otherwise hold
//   op         : ACC_CLR / ACC_DADD / ACC_DSUB / ACC_ADD
//   operand    : already sign-extended to AW
//   acc        : accumulator value
module obc_shift_acc
  import obc_pkg::*;
#(
  parameter int AW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic [AW-1:0] operand,
  output logic [AW-1:0] acc
);
  logic [AW-1:0] dbl;

  assign dbl = {acc[AW-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      unique case (op)
        ACC_CLR:  acc <= '0;
        ACC_DADD: acc <= dbl + operand;
        ACC_DSUB: acc <= dbl - operand;
        default:  acc <= acc + operand;
      endcase
    end
  end
endmodule

// File: rtl/obc_bitserial_sched.sv
// obc_bitserial_sched -- bit-serial sequencer for one OBC partial sum.
// Latches NUM_TAPS signed samples, walks their bit planes MSB-first as the
// ROM address, shift-accumulates the ROM words (MSB plane subtracted), adds
// the offset and presents the result on a valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : sample block handshake (in_samples, k at [k*DW +: DW])
//   rom_bits             : ROM address, bit k = current plane bit of sample k
//   rom_data             : combinational ROM word for rom_bits
//   offset               : OBC offset, used on the OFFS cycle only
//   out_valid/out_ready  : result handshake, out_data signed AW bits
//   busy                 : not IDLE
module obc_bitserial_sched
  import obc_pkg::*;
#(
  parameter  int DW = DEF_DW,
  parameter  int RW = DEF_RW,
  localparam int AW = RW + DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_TAPS*DW-1:0] in_samples,
  output logic [NUM_TAPS-1:0]    rom_bits,
  input  logic [RW-1:0]          rom_data,
  input  logic [RW-1:0]          offset,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_data,
  output logic                   busy
);
  localparam int              PW        = $clog2(DW);
  localparam logic [PW-1:0]   PLANE_MSB = PW'(DW - 1);

  obc_state_e                       state, state_nxt;
  logic [PW-1:0]                    plane, plane_dn;
  logic [NUM_TAPS-1:0][DW-1:0]      in_vec, samp_q;
  logic [NUM_TAPS-1:0]              msb_bits, nxt_bits;
  logic                             accept;
  logic                             acc_en;
  logic [1:0]                       acc_op;
  logic [AW-1:0]                    acc_opnd, acc;

  assign in_vec   = in_samples;
  assign accept   = (state == IDLE) && in_valid;
  assign plane_dn = plane - PW'(1);

  // rom_bits is a register so the ROM sees no path from in_samples: the MSB
  // plane is loaded straight from the input on accept, later planes come
  // from the latched copy one plane ahead of the current one.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign msb_bits[k] = in_vec[k][DW-1];
    assign nxt_bits[k] = samp_q[k][plane_dn];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid)       state_nxt = RUN;
      RUN:  if (plane == '0)    state_nxt = OFFS;
      OFFS:                     state_nxt = DONE;
      DONE: if (out_ready)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // outputs and accumulator control
  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    acc_en    = 1'b0;
    acc_op    = ACC_CLR;
    acc_opnd  = {{DW{rom_data[RW-1]}}, rom_data};
    unique case (state)
      IDLE: acc_en = in_valid;
      RUN: begin
        acc_en = 1'b1;
        acc_op = (plane == PLANE_MSB) ? ACC_DSUB : ACC_DADD;
      end
      OFFS: begin
        acc_en   = 1'b1;
        acc_op   = ACC_ADD;
        acc_opnd = {{DW{offset[RW-1]}}, offset};
      end
      default: ;
    endcase
  end

  // sample latch, plane counter, ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= '0;
      plane    <= PLANE_MSB;
      rom_bits <= '0;
    end else if (accept) begin
      samp_q   <= in_vec;
      plane    <= PLANE_MSB;
      rom_bits <= msb_bits;
    end else if (state == RUN && plane != '0) begin
      plane    <= plane_dn;
      rom_bits <= nxt_bits;
    end
  end

  obc_shift_acc #(.AW(AW)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (acc_en),
    .op      (acc_op),
    .operand (acc_opnd),
    .acc     (acc)
  );

  assign out_data = acc;
endmodule

// File: tb/tb_obc_bitserial_sched.sv
// tb_obc_bitserial_sched -- randomized self-checking bench for obc_bitserial_sched.
// ROM stub modes: 0 constant 16, 1 identity (rom_bits zero-extended),
// 2 linear twiddle ROM (sum of coef[k] over set address bits).
module tb_obc_bitserial_sched;
  localparam int DW = 8;
  localparam int RW = 32;
  localparam int AW = RW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_samples;
  logic [7:0]    rom_bits;
  logic [31:0]   rom_data;
  logic [31:0]   offset;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;
  int rom_mode = 0;
  logic rom_live = 1'b1;
  int rsum;
  int coef [8] = '{2097152, 1482910, 0, -1482910, -2097152, -1482910, 0, 1482910};
  logic [7:0] planes [8];

  always #5 clk = ~clk;

  obc_bitserial_sched #(.DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_samples (in_samples),
    .rom_bits   (rom_bits),
    .rom_data   (rom_data),
    .offset     (offset),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // ROM stub; returns junk when the bench knows the word must be ignored
  always_comb begin
    rsum = 0;
    for (int k = 0; k < 8; k++) if (rom_bits[k]) rsum += coef[k];
    rom_data = 32'hDEAD_BEEF;
    if (rom_live) begin
      case (rom_mode)
        0:       rom_data = 32'd16;
        1:       rom_data = {24'd0, rom_bits};
        default: rom_data = rsum;
      endcase
    end
  end

  // reference: constant ROM gives O-C, a linear ROM gives the plain dot product
  function automatic logic [AW-1:0] ref_model(input logic [63:0] smp, input logic [31:0] off);
    longint r, x;
    r = longint'($signed(off));
    if (rom_mode == 0) r = r - 16;
    else begin
      for (int k = 0; k < 8; k++) begin
        x = longint'($signed(smp[k*8 +: 8]));
        if (rom_mode == 1) r = r + x * (longint'(1) << k);
        else               r = r + longint'(coef[k]) * x;
      end
    end
    return r[AW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // called in cycle 1 after the in-handshake; walks to out_valid, recording
  // rom_bits per RUN cycle and scrambling offset outside the OFFS cycle
  task automatic wait_result(input logic [31:0] off, output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      rom_live = (lat <= DW);
      offset   = (lat == DW + 1) ? off : $urandom;
      if (lat <= DW) planes[lat-1] = rom_bits;
      step();
      lat++;
    end
    rom_live = 1'b0;
    offset   = $urandom;
  endtask

  task automatic run_block(input logic [63:0] smp, input logic [31:0] off,
                           output logic [AW-1:0] res, output int lat);
    int t;
    in_samples = smp;
    in_valid   = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    chk("accept_ready", 64'(in_ready), 64'd1);
    step();
    in_valid   = 1'b0;
    in_samples = {$urandom, $urandom};
    wait_result(off, lat);
    res = out_data;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] res, res0;
    logic [63:0]   smp;
    logic [31:0]   off;
    logic [7:0]    exp_pl [8];
    int            lat, t;

    rst_n = 1'b0; in_valid = 1'b0; in_samples = '0; offset = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_rom_bits",  64'(rom_bits),  64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // constant ROM: result O - C, fixed latency
    rom_mode = 0;
    run_block({$urandom, $urandom}, 32'd100, res, lat);
    chk("const_data", 64'(res), 64'd84);
    chk("const_lat",  64'(lat), 64'd10);
    release_out();

    // identity ROM
    rom_mode = 1;
    run_block(64'h0000_0000_0000_FD05, 32'd0, res, lat);
    chk("ident_5_m3", 64'(res), 64'(40'hFF_FFFF_FFFF));
    release_out();
    run_block(64'h8000_0000_0000_0000, 32'd0, res, lat);
    chk("ident_x7", 64'(res), 64'(40'hFF_FFFF_C000));
    release_out();

    // bit-plane sequencing
    run_block(64'h0000_0000_0000_0180, 32'd0, res, lat);
    exp_pl[0] = 8'h01; exp_pl[7] = 8'h02;
    for (int p = 1; p < 7; p++) exp_pl[p] = 8'h00;
    for (int p = 0; p < 8; p++) chk($sformatf("plane%0d", p), 64'(planes[p]), 64'(exp_pl[p]));
    chk("plane_data", 64'(res), 64'(ref_model(64'h0000_0000_0000_0180, 32'd0)));
    release_out();

    // backpressure in DONE, second in_valid ignored
    rom_mode = 2;
    smp = {$urandom, $urandom};
    off = $urandom;
    run_block(smp, off, res0, lat);
    chk("bp_data", 64'(res0), 64'(ref_model(smp, off)));
    for (int c = 0; c < 20; c++) begin
      in_valid   = 1'b1;
      in_samples = {$urandom, $urandom};
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold",  64'(out_data),  64'(res0));
      chk("bp_ready", 64'(in_ready),  64'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_idle_ready", 64'(in_ready),  64'd1);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_busy",  64'(busy),      64'd0);

    // reset mid-RUN at plane 4
    in_samples = {$urandom, $urandom};
    in_valid   = 1'b1;
    rom_live   = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",     64'(busy),      64'd0);
    chk("mrst_valid",    64'(out_valid), 64'd0);
    chk("mrst_data",     64'(out_data),  64'd0);
    chk("mrst_rom_bits", 64'(rom_bits),  64'd0);
    chk("mrst_ready",    64'(in_ready),  64'd0);
    step();
    rst_n = 1'b1;
    t = 0;
    repeat (12) begin step(); if (out_valid) t++; end
    chk("mrst_no_pulse", 64'(t), 64'd0);
    smp = {$urandom, $urandom};
    off = $urandom;
    run_block(smp, off, res, lat);
    chk("mrst_after", 64'(res), 64'(ref_model(smp, off)));
    release_out();

    // back-to-back with in_valid and out_ready held high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    for (int i = 0; i < 1000; i++) begin
      smp = {$urandom, $urandom};
      off = $urandom;
      in_samples = smp;
      chk("b2b_ready", 64'(in_ready), 64'd1);
      step();
      in_samples = {$urandom, $urandom};
      wait_result(off, lat);
      chk("b2b_lat",  64'(lat),      64'd10);
      chk("b2b_data", 64'(out_data), 64'(ref_model(smp, off)));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    chk("end_idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
